mem_dma: RTL

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma_if.sv | 32 +++
 rtl/mem_dma.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_dma_if.sv
// mem_dma_if -- memory port bundle between the DMA engine and a single-port
// synchronous RAM (port B). The RAM registers its read data, so mem_data_in
// reflects the address presented one cycle earlier.
//
// Signals:
//   mem_address  [14:0]  word address            (DMA -> RAM)
//   mem_data_out [15:0]  write data              (DMA -> RAM)
//   mem_we               write enable            (DMA -> RAM)
//   mem_data_in  [15:0]  registered read data    (RAM -> DMA)
//
// Modports: master = DMA engine side, slave = memory side.

interface mem_dma_if;
    logic [14:0] mem_address;
    logic [15:0] mem_data_out;
    logic        mem_we;
    logic [15:0] mem_data_in;

    modport master (
        output mem_address,
        output mem_data_out,
        output mem_we,
        input  mem_data_in
    );

    modport slave (
        input  mem_address,
        input  mem_data_out,
        input  mem_we,
        output mem_data_in
    );
endinterface

// File: rtl/mem_dma.sv
// mem_dma -- word-granular memory copy/fill engine.
//
// Copy mode reads a source word (READ) and writes it one cycle later (WRITE),
// giving 2 cycles/word; fill mode writes the latched fill word every cycle.
// Transfers run in ascending address order with 15-bit wrapping pointers.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, abort        launch (IDLE only) / terminate (while busy)
//   mode                0 = copy, 1 = fill
//   src_addr, dst_addr  base word addresses (15 bit)
//   length              word count, 0..32768
//   fill_value          word written in fill mode
//   busy, done          transfer active / one-cycle completion pulse
//   words_done          words written in the current or last transfer
//   mem                 memory port (mem_dma_if.master)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; memory outputs held at 0
// S_READ  | copy only: present src_ptr, data returns next cycle
// S_WRITE | write one word at dst_ptr, advance pointers and count
// S_DONE  | one-cycle done pulse, then back to idle

module mem_dma (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [14:0] src_addr,
    input  logic [14:0] dst_addr,
    input  logic [15:0] length,
    input  logic [15:0] fill_value,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_done,
    mem_dma_if.master   mem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] src_ptr_q, src_ptr_d;
    logic [14:0] dst_ptr_q, dst_ptr_d;
    logic [15:0] len_q, len_d;
    logic        mode_q, mode_d;
    logic [15:0] fill_q, fill_d;
    logic [15:0] words_done_q, words_done_d;

    logic        last_word;

    // The write in flight is the final one when the count after it hits length.
    assign last_word = ((words_done_q + 16'd1) == len_q);

    always_comb begin
        state_d          = state_q;
        src_ptr_d        = src_ptr_q;
        dst_ptr_d        = dst_ptr_q;
        len_d            = len_q;
        mode_d           = mode_q;
        fill_d           = fill_q;
        words_done_d     = words_done_q;
        busy             = 1'b0;
        done             = 1'b0;
        mem.mem_address  = 15'd0;
        mem.mem_data_out = 16'd0;
        mem.mem_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_done_d = 16'd0;
                    if (length == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        src_ptr_d = src_addr;
                        dst_ptr_d = dst_addr;
                        len_d     = length;
                        mode_d    = mode;
                        fill_d    = fill_value;
                        state_d   = mode ? S_WRITE : S_READ;
                    end
                end
            end

            S_READ: begin
                busy            = 1'b1;
                mem.mem_address = src_ptr_q;
                state_d         = abort ? S_IDLE : S_WRITE;
            end

            S_WRITE: begin
                busy             = 1'b1;
                mem.mem_address  = dst_ptr_q;
                mem.mem_we       = 1'b1;
                // Copy data is the RAM's registered output for the READ address.
                mem.mem_data_out = mode_q ? fill_q : mem.mem_data_in;
                // The write issued this cycle always lands, even under abort.
                src_ptr_d        = src_ptr_q + 15'd1;
                dst_ptr_d        = dst_ptr_q + 15'd1;
                words_done_d     = words_done_q + 16'd1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    state_d = mode_q ? S_WRITE : S_READ;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= 15'd0;
            dst_ptr_q    <= 15'd0;
            len_q        <= 16'd0;
            mode_q       <= 1'b0;
            fill_q       <= 16'd0;
            words_done_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            len_q        <= len_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            words_done_q <= words_done_d;
        end
    end

    assign words_done = words_done_q;

endmodule
